// File: rtl/pio_loader.sv
// Purpose : loads PROG_LEN instruction words and up to CONF_MAX config entries into a PIO
//           block through one command port, then hands the port over to a host.
// Latency : first write lands 2 cycles after start is accepted (synchronous memory read + output register).
// Backpressure: host_ready is low outside RUN and whenever start is high; a start request is ignored while a load is in progress.
//
// Ports:
//   clk, n_reset                 clock, asynchronous active-low reset
//   start, conf_len, cfg_mindex  load request and its parameters, sampled when start is accepted
//   prog_addr / prog_data        instruction memory read port (data one cycle after address)
//   conf_addr / conf_data        config memory read port {action[35:32], din[31:0]}
//   host_*                       host command port, accepted on host_valid & host_ready
//   action, index, mindex, din   registered PIO command port (action==0 means no command)
//   busy, done, err              load in progress, completion pulse, sticky length overflow
module pio_loader #(
    parameter int PROG_LEN = 32,
    parameter int CONF_MAX = 32
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [5:0]  conf_len,
    input  logic [1:0]  cfg_mindex,
    output logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    output logic [4:0]  conf_addr,
    input  logic [35:0] conf_data,
    input  logic        host_valid,
    input  logic [5:0]  host_action,
    input  logic [4:0]  host_index,
    input  logic [1:0]  host_mindex,
    input  logic [31:0] host_din,
    output logic        host_ready,
    output logic [5:0]  action,
    output logic [4:0]  index,
    output logic [1:0]  mindex,
    output logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [5:0] PROG_LEN_W = 6'(PROG_LEN);
    localparam logic [5:0] CONF_MAX_W = 6'(CONF_MAX);

    typedef enum logic [1:0] {IDLE, PROG, CONF, RUN} state_t;

    state_t      state;
    logic [5:0]  cnt;        // PROG: last issued word (reaches PROG_LEN as the fill slot); CONF: last issued entry
    logic [5:0]  len_q;      // saturated config length
    logic [1:0]  mindex_q;
    logic        first_q;    // first CONF cycle: nothing can be in flight yet
    // Two-stage read pipeline: rd_* tracks the address presented this cycle,
    // d_* tracks the memory word present on the data input this cycle.
    logic        rd_vld, rd_conf;
    logic [4:0]  rd_idx;
    logic        d_vld, d_conf;
    logic [4:0]  d_idx;

    logic [5:0]  cnt_nxt;
    logic [5:0]  len_sat;
    logic        start_ok;
    logic        host_acc;

    assign cnt_nxt    = cnt + 6'd1;
    assign len_sat    = (conf_len > CONF_MAX_W) ? CONF_MAX_W : conf_len;
    assign start_ok   = start && ((state == IDLE) || (state == RUN));
    assign host_ready = (state == RUN) && !start;
    assign host_acc   = host_valid && host_ready;
    assign busy       = (state == PROG) || (state == CONF);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            len_q     <= 6'd0;
            mindex_q  <= 2'd0;
            first_q   <= 1'b0;
            rd_vld    <= 1'b0;
            rd_conf   <= 1'b0;
            rd_idx    <= 5'd0;
            d_vld     <= 1'b0;
            d_conf    <= 1'b0;
            d_idx     <= 5'd0;
            prog_addr <= 5'd0;
            conf_addr <= 5'd0;
            action    <= 6'd0;
            index     <= 5'd0;
            mindex    <= 2'd0;
            din       <= 32'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done   <= 1'b0;
            action <= 6'd0;
            d_vld  <= rd_vld;
            d_conf <= rd_conf;
            d_idx  <= rd_idx;

            // Retire the memory word that arrived this cycle.
            if (d_vld) begin
                if (!d_conf) begin
                    action <= 6'd1;
                    index  <= d_idx;
                    mindex <= 2'd0;
                    din    <= {16'h0000, prog_data};
                end else begin
                    action <= {2'b00, conf_data[35:32]};
                    index  <= 5'd0;
                    mindex <= mindex_q;
                    din    <= conf_data[31:0];
                end
            end

            case (state)
                IDLE, RUN: begin
                    if (start_ok) begin
                        state     <= PROG;
                        len_q     <= len_sat;
                        mindex_q  <= cfg_mindex;
                        err       <= (conf_len > CONF_MAX_W);
                        cnt       <= 6'd0;
                        prog_addr <= 5'd0;
                        conf_addr <= 5'd0;
                        rd_vld    <= 1'b1;
                        rd_conf   <= 1'b0;
                        rd_idx    <= 5'd0;
                    end else if (host_acc) begin
                        action <= host_action;
                        index  <= host_index;
                        mindex <= host_mindex;
                        din    <= host_din;
                    end
                end
                PROG: begin
                    // cnt==PROG_LEN is the idle issue slot that becomes the
                    // single action=0 fill cycle between PROG and CONF writes.
                    if (cnt == PROG_LEN_W) begin
                        state     <= CONF;
                        cnt       <= 6'd0;
                        conf_addr <= 5'd0;
                        rd_vld    <= (len_q != 6'd0);
                        rd_conf   <= 1'b1;
                        rd_idx    <= 5'd0;
                        first_q   <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt < PROG_LEN_W) begin
                            prog_addr <= cnt_nxt[4:0];
                            rd_vld    <= 1'b1;
                            rd_idx    <= cnt_nxt[4:0];
                        end else begin
                            rd_vld <= 1'b0;
                        end
                    end
                end
                CONF: begin
                    first_q <= 1'b0;
                    if (!first_q && !rd_vld && !d_vld) begin
                        state <= RUN;
                        done  <= 1'b1;
                    end else if (rd_vld && (cnt_nxt < len_q)) begin
                        cnt       <= cnt_nxt;
                        conf_addr <= cnt_nxt[4:0];
                        rd_idx    <= cnt_nxt[4:0];
                    end else begin
                        rd_vld <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_loader.sv
module tb_pio_loader;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start;
    logic [5:0]  conf_len;
    logic [1:0]  cfg_mindex;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  conf_addr;
    logic [35:0] conf_data;
    logic        host_valid;
    logic [5:0]  host_action;
    logic [4:0]  host_index;
    logic [1:0]  host_mindex;
    logic [31:0] host_din;
    logic        host_ready;
    logic [5:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] prog_mem [32];
    logic [35:0] conf_mem [32];

    always #5 clk = ~clk;

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        prog_data <= prog_mem[prog_addr];
        conf_data <= conf_mem[conf_addr];
    end

    pio_loader #(.PROG_LEN(32), .CONF_MAX(32)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .conf_len(conf_len),
        .cfg_mindex(cfg_mindex), .prog_addr(prog_addr), .prog_data(prog_data),
        .conf_addr(conf_addr), .conf_data(conf_data), .host_valid(host_valid),
        .host_action(host_action), .host_index(host_index), .host_mindex(host_mindex),
        .host_din(host_din), .host_ready(host_ready), .action(action), .index(index),
        .mindex(mindex), .din(din), .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full load from a start pulse to the cycle after done, checked cycle by cycle.
    task automatic do_load(input logic [5:0] len, input logic [1:0] mi, input int exp_n,
                           input bit exp_err, input bit host_at_start,
                           input bit pulse_in_prog, input bit host_in_conf);
        @(negedge clk);
        start = 1'b1; conf_len = len; cfg_mindex = mi;
        if (host_at_start) begin
            host_valid = 1'b1; host_action = 6'd9; host_index = 5'd7;
            host_mindex = 2'd3; host_din = 32'h1234_5678;
            #1 check("host_rdy_vs_start", host_ready, 0);
        end
        @(negedge clk);
        start = 1'b0; host_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_act", action, 0);
        check("accept_err", err, exp_err);
        @(negedge clk);
        check("prefetch_act", action, 0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check("prog_act", action, 1);
            check("prog_idx", index, k);
            check("prog_mindex", mindex, 0);
            check("prog_din", din, {16'h0000, prog_mem[k]});
            check("prog_done", done, 0);
            if (pulse_in_prog) start = (k == 5);
        end
        @(negedge clk);
        check("fill_act", action, 0);
        check("fill_busy", busy, 1);
        if (host_in_conf) begin
            host_valid = 1'b1; host_action = 6'd5; host_index = 5'd1;
            host_mindex = 2'd1; host_din = 32'h0BAD_F00D;
        end
        for (int j = 0; j < exp_n; j++) begin
            @(negedge clk);
            check("conf_act", action, {2'b00, conf_mem[j][35:32]});
            check("conf_din", din, conf_mem[j][31:0]);
            check("conf_idx", index, 0);
            check("conf_mindex", mindex, mi);
            if (host_in_conf) check("conf_host_rdy", host_ready, 0);
        end
        host_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_act", action, 0);
        check("done_busy", busy, 0);
        check("done_err", err, exp_err);
        @(negedge clk);
        check("done_once", done, 0);
        check("run_host_rdy", host_ready, 1);
    endtask

    initial begin
        int quiet_bad;
        for (int k = 0; k < 32; k++) begin
            prog_mem[k] = 16'hA500 ^ (16'(k) * 16'h0111);
            conf_mem[k] = {4'(k % 16), 32'hC0DE_0000 | 32'(k)};
        end
        n_reset = 1'b0; start = 1'b0; conf_len = 6'd0; cfg_mindex = 2'd0;
        host_valid = 1'b0; host_action = 6'd0; host_index = 5'd0;
        host_mindex = 2'd0; host_din = 32'd0;

        // Reset state
        #12;
        check("rst_action", action, 0);
        check("rst_index", index, 0);
        check("rst_din", din, 0);
        check("rst_addrs", {prog_addr, conf_addr}, 0);
        check("rst_flags", {busy, done, err, host_ready}, 0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_act", action, 0);

        // Normal load with start pulse during PROG and host_valid during CONF
        do_load(6'd4, 2'd2, 4, 1'b0, 1'b0, 1'b1, 1'b1);

        // Host command in RUN
        @(negedge clk);
        host_valid = 1'b1; host_action = 6'd5; host_index = 5'd3;
        host_mindex = 2'd1; host_din = 32'hDEAD_BEEF;
        #1 check("host_rdy_run", host_ready, 1);
        @(negedge clk);
        host_valid = 1'b0;
        check("host_act", action, 5);
        check("host_idx", index, 3);
        check("host_mindex", mindex, 1);
        check("host_din", din, 32'hDEAD_BEEF);
        @(negedge clk);
        check("host_act_clr", action, 0);
        check("host_idx_hold", index, 3);
        check("host_din_hold", din, 32'hDEAD_BEEF);

        // Zero-length config, start coinciding with a host command
        do_load(6'd0, 2'd1, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Over-length config saturates to 32 entries and raises err
        do_load(6'd40, 2'd3, 32, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);

        // Next start clears err
        do_load(6'd4, 2'd0, 4, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset at PROG write 10
        @(negedge clk);
        start = 1'b1; conf_len = 6'd4; cfg_mindex = 2'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_rst_write10", {action, 1'b0, index}, {6'd1, 1'b0, 5'd10});
        n_reset = 1'b0;
        #1;
        check("arst_action", action, 0);
        check("arst_index", index, 0);
        check("arst_din", din, 0);
        check("arst_addrs", {prog_addr, conf_addr}, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        n_reset = 1'b1;
        quiet_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (action != 6'd0 || done || busy || host_ready) quiet_bad++;
        end
        check("post_rst_quiet", quiet_bad, 0);

        // Recovery after reset
        do_load(6'd1, 2'd2, 1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_loader.md
PIO_LOADER -- requirements
Module: pio_loader

Interface
REQ-001 Parameter PROG_LEN, default 32: number of instruction words loaded, range 1..32.
REQ-002 Parameter CONF_MAX, default 32: maximum configuration entries, range 1..32.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 n_reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a full program+config load; sampled every cycle.
REQ-006 conf_len  in  6  number of config entries to apply; sampled when start is accepted.
REQ-007 cfg_mindex  in  2  target machine index for config writes; sampled when start is accepted.
REQ-008 prog_addr  out  5  instruction memory read address.
REQ-009 prog_data  in  16  instruction word; valid one cycle after prog_addr.
REQ-010 conf_addr  out  5  config memory read address.
REQ-011 conf_data  in  36  config entry {action[35:32], din[31:0]}; valid one cycle after conf_addr.
REQ-012 host_valid, host_action[5:0], host_index[4:0], host_mindex[1:0], host_din[31:0]  in  host command port.
REQ-013 host_ready  out  1  host command accepted when host_valid & host_ready.
REQ-014 action  out  6, index  out  5, mindex  out  2, din  out  32  registered PIO command port.
REQ-015 busy  out  1  high in PROG, CONF.
REQ-016 done  out  1  one-cycle pulse at load completion.
REQ-017 err  out  1  sticky: conf_len exceeded CONF_MAX.

Function
REQ-018 States: IDLE, PROG, CONF, RUN; transitions only as stated below.
REQ-019 start accepted only in IDLE or RUN; ignored in PROG/CONF.
REQ-020 Accept: latch conf_len (saturated to CONF_MAX), cfg_mindex; clear err, then set err if conf_len > CONF_MAX; enter PROG.
REQ-021 PROG: prog_addr steps 0..PROG_LEN-1, one per cycle, from first PROG cycle.
REQ-022 PROG writes: action=1, index=k, mindex=0, din={16'h0, prog_data} for word k; exactly PROG_LEN consecutive cycles, first write 2 cycles after start-accept edge.
REQ-023 After last PROG write, exactly one cycle with action=0 (conf read fill), then CONF writes; if latched length is 0, skip CONF.
REQ-024 CONF write j: action={2'b00, conf_data[35:32]}, din=conf_data[31:0], index=0, mindex=latched cfg_mindex; one per cycle, j=0..len-1.
REQ-025 Entry with conf_data[35:32]=0 still consumes one cycle, issues action=0.
REQ-026 Cycle after last write (or after the fill cycle if len=0): action=0, done=1 for one cycle, state RUN.
REQ-027 busy=1 exactly while state is PROG or CONF.
REQ-028 host_ready = (state==RUN) & ~start, combinational.
REQ-029 RUN: accepted host command drives action/index/mindex/din on next cycle for exactly one cycle; otherwise action=0, other fields hold.
REQ-030 start and host_valid same cycle in RUN: start wins, host command not accepted.
REQ-031 start in RUN restarts load from REQ-020; no host command issued that cycle.
REQ-032 Outside a write cycle action=0 always; at most one command per cycle.

Reset
REQ-033 n_reset low: immediately IDLE; action, index, mindex, din, prog_addr, conf_addr=0; busy, done, err=0; host_ready=0.
REQ-034 Reset mid-PROG/CONF aborts load; no done; after release, IDLE until start.

Verification
REQ-035 PROG_LEN=32, conf_len=4, start pulse -> 32 cycles action=1 index 0..31 with matching data, 1 idle, 4 config writes, done pulse, then host_ready=1.
REQ-036 conf_len=0 -> PROG writes, one idle cycle, done next cycle; no action=2..15 observed.
REQ-037 conf_len=40, CONF_MAX=32 -> exactly 32 config writes, err=1 until next start.
REQ-038 RUN: host_valid with action=5, index=3, din=32'hDEADBEEF -> next cycle identical outputs, then action=0; simultaneous start -> host ignored, reload begins.
REQ-039 start pulses during PROG -> ignored, single done; host_valid during CONF -> host_ready=0.
REQ-040 n_reset asserted at PROG write 10 -> outputs zero asynchronously; after release, no activity until start.
